// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Brief    : ALU execution stage; logic/arith ops in one cycle, shifts one
//            bit per cycle, valid/ready handshake on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_slt = 3'b101;
    localparam logic [2:0] c_op_sll = 3'b110;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [SHW-1:0]   r_count;
    logic [SHW-1:0]   w_count_nxt;
    logic             r_dir_left;
    logic             w_dir_left_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_zero_nxt;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_shifted;
    logic [SHW-1:0]   w_count_dec;
    logic             w_slt;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign w_slt       = ($signed(src_a) < $signed(src_b));
    assign w_shifted   = r_dir_left ? (r_shreg << 1) : (r_shreg >> 1);
    assign w_count_dec = r_count - SHW'(1);

    always_comb begin
        w_single = '0;
        case (ALU_control)
            c_op_add: w_single = src_a + src_b;
            c_op_sub: w_single = src_a - src_b;
            c_op_and: w_single = src_a & src_b;
            c_op_or:  w_single = src_a | src_b;
            c_op_xor: w_single = src_a ^ src_b;
            c_op_slt: w_single = {{(WIDTH-1){1'b0}}, w_slt};
            default:  w_single = '0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_count_nxt    = r_count;
        w_dir_left_nxt = r_dir_left;
        w_result_nxt   = alu_result;
        w_zero_nxt     = zero;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALU_control[2:1] == 2'b11) begin
                        w_dir_left_nxt = (ALU_control == c_op_sll);
                        w_shreg_nxt    = src_a;
                        w_count_nxt    = src_b[SHW-1:0];
                        if (src_b[SHW-1:0] == '0) begin
                            w_result_nxt = src_a;
                            w_zero_nxt   = (src_a == '0);
                            w_state_nxt  = S_DONE;
                        end else begin
                            w_state_nxt  = S_SHIFT;
                        end
                    end else begin
                        w_result_nxt = w_single;
                        w_zero_nxt   = (w_single == '0);
                        w_state_nxt  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                w_shreg_nxt = w_shifted;
                w_count_nxt = w_count_dec;
                if (w_count_dec == '0) begin
                    w_result_nxt = w_shifted;
                    w_zero_nxt   = (w_shifted == '0);
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                // Result is taken this cycle; a new request waits for IDLE.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_count    <= '0;
            r_dir_left <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_count    <= w_count_nxt;
            r_dir_left <= w_dir_left_nxt;
            alu_result <= w_result_nxt;
            zero       <= w_zero_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_alu
// Brief    : Directed-vector self-checking bench for iterative_alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALU_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        zero;

    int n_checks;
    int n_pass;

    iterative_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALU_control (ALU_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency counts edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        logic ir_seen;
        ALU_control = op;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        ALU_control = 3'bxxx;
        src_a       = 32'hxxxx_xxxx;
        src_b       = 32'hxxxx_xxxx;
        lat     = 1;
        ir_seen = in_ready;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            ir_seen = ir_seen | in_ready;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " result"}, alu_result, exp);
        check_eq({tag, " zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
        check_eq({tag, " in_ready busy"}, {31'd0, ir_seen}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, " hold result"}, alu_result, exp);
            check_eq({tag, " hold flags"}, {29'd0, out_valid, in_ready, zero},
                     {29'd0, 1'b1, 1'b0, exp == 32'd0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, " idle after take"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    endtask

    initial begin
        int stale;
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        ALU_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("reset flags", {29'd0, in_ready, out_valid, zero}, {29'd0, 1'b1, 1'b0, 1'b0});
        check_eq("reset result", alu_result, 32'd0);

        run_op("add",  3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1, 0);
        run_op("sub",  3'b001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1, 0);
        run_op("slt",  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0);
        run_op("slt swap", 3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        run_op("and",  3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 0);
        run_op("or",   3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1, 0);
        run_op("xor",  3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1, 0);
        run_op("sll5", 3'b110, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 6, 0);
        run_op("srl31", 3'b111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32, 0);
        run_op("sll0", 3'b110, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1, 0);
        run_op("srl hi bits", 3'b111, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 5, 0);
        run_op("add wrap bp", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 4);
        run_op("sub b2b", 3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0);

        // Reset asserted on the 7th edge counted from the accept edge.
        ALU_control = 3'b110;
        src_a       = 32'h0000_0001;
        src_b       = 32'h0000_0014;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid shift busy", {30'd0, in_ready, out_valid}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst flags", {29'd0, in_ready, out_valid, zero}, {29'd0, 1'b1, 1'b0, 1'b0});
        check_eq("rst result", alu_result, 32'd0);
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid || alu_result != 32'd0) stale++;
        end
        check_eq("no stale result", 32'(stale), 32'd0);

        run_op("post rst add", 3'b000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
